// File: rtl/otter_timer_intr.sv
// Memory-mapped down-counter timer for the OTTER I/O bus.
// Four registers (CTRL, COUNT, RELOAD, STATUS) with a level interrupt on expiry.
module otter_timer_intr #(
    parameter logic [31:0] BASE_ADDR = 32'h1100_0100,
    parameter int          CNT_W     = 32
) (
    input  logic        CLK,
    input  logic        RST,
    input  logic [31:0] IOBUS_ADDR,
    input  logic [31:0] IOBUS_OUT,
    input  logic        IOBUS_WR,
    output logic [31:0] RD_DATA,
    output logic        INTR
);

    typedef enum logic {IDLE, RUN} state_t;

    state_t           state, state_nxt;
    logic             auto_rl, ie, exp_flag;
    logic [7:0]       prescale, ps;
    logic [CNT_W-1:0] count, reload;

    logic hit, wr_ctrl, wr_count, wr_reload, wr_status;
    logic tick, cnt_zero, expire;
    logic unused_addr;

    assign unused_addr = ^IOBUS_ADDR[1:0];

    assign hit       = (IOBUS_ADDR[31:4] == BASE_ADDR[31:4]);
    assign wr_ctrl   = IOBUS_WR && hit && (IOBUS_ADDR[3:2] == 2'd0);
    assign wr_count  = IOBUS_WR && hit && (IOBUS_ADDR[3:2] == 2'd1);
    assign wr_reload = IOBUS_WR && hit && (IOBUS_ADDR[3:2] == 2'd2);
    assign wr_status = IOBUS_WR && hit && (IOBUS_ADDR[3:2] == 2'd3);

    assign tick     = (state == RUN) && (ps == prescale);
    assign cnt_zero = (count == '0);
    // A COUNT write on the tick cycle takes priority and suppresses expiry.
    assign expire   = tick && cnt_zero && !wr_count;

    always_ff @(posedge CLK) begin
        if (RST) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        if (wr_ctrl)
            state_nxt = IOBUS_OUT[0] ? RUN : IDLE;
        else if (expire && !auto_rl)
            state_nxt = IDLE;
    end

    always_ff @(posedge CLK) begin
        if (RST || wr_ctrl || state != RUN || tick) ps <= 8'd0;
        else                                        ps <= ps + 8'd1;
    end

    always_ff @(posedge CLK) begin
        if (RST) begin
            auto_rl  <= 1'b0;
            ie       <= 1'b0;
            prescale <= 8'd0;
        end else if (wr_ctrl) begin
            auto_rl  <= IOBUS_OUT[1];
            ie       <= IOBUS_OUT[2];
            prescale <= IOBUS_OUT[15:8];
        end
    end

    always_ff @(posedge CLK) begin
        if (RST)            reload <= '0;
        else if (wr_reload) reload <= IOBUS_OUT[CNT_W-1:0];
    end

    always_ff @(posedge CLK) begin
        if (RST)
            count <= '0;
        else if (wr_count)
            count <= IOBUS_OUT[CNT_W-1:0];
        else if (tick) begin
            if (!cnt_zero)    count <= count - CNT_W'(1);
            else if (auto_rl) count <= reload;
        end
    end

    // Set beats a simultaneous software clear so no expiry is lost.
    always_ff @(posedge CLK) begin
        if (RST)                          exp_flag <= 1'b0;
        else if (expire)                  exp_flag <= 1'b1;
        else if (wr_status && IOBUS_OUT[0]) exp_flag <= 1'b0;
    end

    always_comb begin
        RD_DATA = 32'd0;
        if (hit) begin
            case (IOBUS_ADDR[3:2])
                2'd0:    RD_DATA = {16'd0, prescale, 5'd0, ie, auto_rl, state == RUN};
                2'd1:    RD_DATA = 32'(count);
                2'd2:    RD_DATA = 32'(reload);
                default: RD_DATA = {31'd0, exp_flag};
            endcase
        end
    end

    assign INTR = exp_flag & ie;

endmodule

// File: tb/tb_otter_timer_intr.sv
// Scoreboard bench for otter_timer_intr: expectations queued at stimulus time,
// drained and compared at the following falling edge.
module tb_otter_timer_intr;

    localparam logic [31:0] BASE     = 32'h1100_0100;
    localparam logic [31:0] A_CTRL   = BASE;
    localparam logic [31:0] A_COUNT  = BASE + 32'h4;
    localparam logic [31:0] A_RELOAD = BASE + 32'h8;
    localparam logic [31:0] A_STATUS = BASE + 32'hC;
    localparam logic [31:0] A_OTHER  = BASE ^ 32'h1000_0000;

    logic        CLK = 1'b0;
    logic        RST;
    logic [31:0] IOBUS_ADDR, IOBUS_OUT;
    logic        IOBUS_WR;
    logic [31:0] RD_DATA;
    logic        INTR;

    int n_cmp = 0;
    int n_bad = 0;

    typedef struct {
        string       tag;
        bit          is_intr;
        logic [31:0] val;
    } sb_t;
    sb_t sb_q[$];

    otter_timer_intr #(.BASE_ADDR(BASE), .CNT_W(32)) dut (
        .CLK(CLK), .RST(RST), .IOBUS_ADDR(IOBUS_ADDR), .IOBUS_OUT(IOBUS_OUT),
        .IOBUS_WR(IOBUS_WR), .RD_DATA(RD_DATA), .INTR(INTR)
    );

    always #5 CLK = ~CLK;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] want);
        n_cmp++;
        if (obs !== want) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, obs, want);
        end
    endtask

    always @(negedge CLK) begin
        while (sb_q.size() > 0) begin
            sb_t e;
            e = sb_q.pop_front();
            if (e.is_intr) chk(e.tag, {31'd0, INTR}, e.val);
            else           chk(e.tag, RD_DATA, e.val);
        end
    end

    task automatic step();
        @(posedge CLK);
        #1;
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] d);
        IOBUS_ADDR = a;
        IOBUS_OUT  = d;
        IOBUS_WR   = 1'b1;
        step();
        IOBUS_WR   = 1'b0;
    endtask

    task automatic exp_rd(input string tag, input logic [31:0] a, input logic [31:0] v);
        sb_t e;
        IOBUS_ADDR = a;
        e.tag = tag; e.is_intr = 1'b0; e.val = v;
        sb_q.push_back(e);
    endtask

    task automatic exp_intr(input string tag, input bit v);
        sb_t e;
        e.tag = tag; e.is_intr = 1'b1; e.val = {31'd0, v};
        sb_q.push_back(e);
    endtask

    initial begin
        RST = 1'b1; IOBUS_ADDR = 32'd0; IOBUS_OUT = 32'd0; IOBUS_WR = 1'b0;
        step(); step();
        RST = 1'b0;

        // zero count expires on the first tick, then reset clears everything
        wr(A_RELOAD, 32'h55);
        wr(A_COUNT, 32'd0);
        wr(A_CTRL, 32'h5);
        exp_intr("zero_pre", 1'b0); step();
        exp_intr("zero_exp", 1'b1); step();
        wr(A_COUNT, 32'd7);
        RST = 1'b1; step(); step(); RST = 1'b0;
        exp_rd("rst_ctrl", A_CTRL, 32'd0);     exp_intr("rst_intr", 1'b0); step();
        exp_rd("rst_count", A_COUNT, 32'd0);   step();
        exp_rd("rst_reload", A_RELOAD, 32'd0); step();
        exp_rd("rst_status", A_STATUS, 32'd0); step();

        // one-shot: COUNT=3, P=0 -> INTR 4 cycles after the CTRL edge
        wr(A_COUNT, 32'd3);
        wr(A_CTRL, 32'h5);
        for (int k = 0; k < 4; k++) begin
            exp_intr("os_low", 1'b0); step();
        end
        exp_intr("os_rise", 1'b1); exp_rd("os_ctrl", A_CTRL, 32'h4); step();
        exp_rd("os_count", A_COUNT, 32'd0); exp_intr("os_hold", 1'b1); step();
        wr(A_STATUS, 32'h1);
        exp_intr("os_clr", 1'b0); exp_rd("os_status", A_STATUS, 32'd0); step();

        // auto-reload with prescale 2: ticks every 3 cycles, expiry every 9
        wr(A_RELOAD, 32'd2);
        wr(A_COUNT, 32'd2);
        wr(A_CTRL, 32'h0207);
        for (int k = 0; k < 18; k++) begin
            exp_rd("ar_count", A_COUNT, 32'(2 - (k / 3) % 3));
            exp_intr("ar_intr", k >= 9);
            step();
        end
        exp_rd("ar_status", A_STATUS, 32'd1);
        wr(A_STATUS, 32'h1);
        for (int k = 19; k < 28; k++) begin
            exp_rd("ar_count2", A_COUNT, 32'(2 - (k / 3) % 3));
            exp_intr("ar_intr2", k == 27);
            step();
        end
        wr(A_CTRL, 32'h0);
        wr(A_STATUS, 32'h1);

        // COUNT write on the expiry tick wins
        wr(A_COUNT, 32'd1);
        wr(A_CTRL, 32'h5);
        step();
        wr(A_COUNT, 32'd5);
        exp_rd("col_count", A_COUNT, 32'd5);   exp_intr("col_intr", 1'b0); step();
        exp_rd("col_status", A_STATUS, 32'd0); step();
        wr(A_CTRL, 32'h0);
        wr(A_STATUS, 32'h1);

        // STATUS clear on the expiry tick loses to the set
        wr(A_COUNT, 32'd1);
        wr(A_CTRL, 32'h5);
        step();
        wr(A_STATUS, 32'h1);
        exp_rd("clr_status", A_STATUS, 32'd1); exp_intr("clr_intr", 1'b1); step();
        exp_rd("clr_ctrl", A_CTRL, 32'h4); step();

        // address decode
        wr(A_STATUS, 32'h1);
        wr(BASE + 32'h10, 32'h99);
        wr(A_OTHER, 32'h1);
        wr(A_OTHER | 32'h4, 32'h77);
        exp_rd("dec_count", A_COUNT, 32'd0);     exp_intr("dec_intr", 1'b0); step();
        exp_rd("dec_ctrl", A_CTRL, 32'h4);       step();
        exp_rd("dec_reload", A_RELOAD, 32'd2);   step();
        exp_rd("dec_oow", BASE + 32'h10, 32'd0); step();
        exp_rd("dec_other", A_OTHER, 32'd0);     step();
        wr(BASE + 32'h7, 32'h33);
        exp_rd("dec_low_bits", A_COUNT, 32'h33); step();

        // reset mid-run with INTR high
        wr(A_RELOAD, 32'd100);
        wr(A_COUNT, 32'd0);
        wr(A_CTRL, 32'h7);
        step();
        exp_rd("mr_count", A_COUNT, 32'd100); exp_intr("mr_intr", 1'b1); step();
        exp_rd("mr_count2", A_COUNT, 32'd99); exp_intr("mr_intr2", 1'b1);
        RST = 1'b1; step(); RST = 1'b0;
        exp_rd("mr_ctrl", A_CTRL, 32'd0);     exp_intr("mr_drop", 1'b0); step();
        exp_rd("mr_count0", A_COUNT, 32'd0);  step();
        exp_rd("mr_reload", A_RELOAD, 32'd0); step();
        exp_rd("mr_status", A_STATUS, 32'd0); step();
        for (int k = 0; k < 5; k++) begin
            exp_intr("mr_quiet", 1'b0); step();
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/otter_timer_intr.md
# otter_timer_intr

Memory-mapped programmable down-counter timer on the OTTER I/O bus. It decodes word-aligned addresses on IOBUS_ADDR, takes writes from IOBUS_OUT when IOBUS_WR is high, and returns register contents for the top-level IOBUS_IN mux. On expiry it raises a level interrupt that connects to the MCU INTR input, where CSR_ME gates it. It is the first interrupt source for the MCU's trap path.

## Interface

- BASE_ADDR, 32'h1100_0100: word-aligned base of the 4-register window (BASE+0x0 to BASE+0xC).
- CNT_W, 32: counter and reload width (1..32; registers zero-extend on read).
- CLK  input  1  system clock, rising edge.
- RST  input  1  reset. Synchronous and active-high.
- IOBUS_ADDR  input  32  bus address from the MCU ALU result.
- IOBUS_OUT  input  32  write data (rs2).
- IOBUS_WR  input  1  write strobe, one cycle per store.
- RD_DATA  output  32  read data for the IOBUS_IN mux. Value is 0 when the address is outside the window.
- INTR  output  1  level interrupt request to the MCU.

## Operation

- Registers:
  - CTRL @+0x0: bit0 EN, bit1 AUTO (auto-reload), bit2 IE (interrupt enable), bits[15:8] PRESCALE. All other bits read 0.
  - COUNT @+0x4: current count. A write loads the counter.
  - RELOAD @+0x8: value loaded on expiry when AUTO=1.
  - STATUS @+0xC: bit0 EXP (expired flag). Writing 1 to bit0 clears it; writing 0 has no effect.
- Address decode: match IOBUS_ADDR[31:4] == BASE_ADDR[31:4]. Bits [3:2] select the register. Bits [1:0] are ignored. Writes outside the window are ignored.
- Prescaler: 8-bit counter PS.
  - While EN=1, PS increments each cycle.
  - When PS == PRESCALE, a tick fires and PS returns to 0. The result is one tick every PRESCALE+1 cycles.
  - While EN=0, PS is held at 0.
- State machine, two states:
  - IDLE (EN=0): the counter holds its value.
  - RUN (EN=1): on each tick:
    - If COUNT != 0: COUNT -= 1.
    - If COUNT == 0: EXP is set. Then if AUTO=1, COUNT <= RELOAD and the state stays RUN. If AUTO=0, EN is cleared and the state goes to IDLE (one-shot).
- Transitions: a CTRL write with bit0=1 enters RUN; a CTRL write with bit0=0 enters IDLE. Any CTRL write clears PS.
- Arithmetic: the decrement is modulo 2^CNT_W. It never underflows, because 0 is the expiry condition. COUNT=0 at EN set expires on the first tick.
- INTR = EXP & IE, combinational from registered state. It stays high until software clears EXP or IE.
- Simultaneous events:
  - A COUNT write in the same cycle as a tick: the write wins, and no decrement or expiry occurs.
  - A STATUS clear in the same cycle as an expiry: the set wins, so EXP stays 1.
  - A CTRL write in the same cycle as an expiry: CTRL takes the written value, EXP is still set, and any reload still occurs.
- RELOAD writes do not disturb a running count.

## Timing

- All state updates happen on the rising edge of CLK. RD_DATA is combinational from IOBUS_ADDR and the registers, with zero wait states.
- Reset (RST=1 at an edge): CTRL, COUNT, RELOAD, EXP and PS all go to 0. INTR=0. RD_DATA is 0 for in-window reads of those registers. Reset mid-count aborts the count immediately, and any pending INTR drops the cycle after the reset edge.
- Write latency: a register value is visible on RD_DATA one cycle after the IOBUS_WR edge.
- Expiry latency: EXP and INTR rise on the edge of the tick where COUNT==0.
- With PRESCALE=P and a COUNT=N load followed by enable, INTR rises (N+1)(P+1) cycles after the CTRL-write edge.
- A write of 1 to STATUS drops INTR on the next edge.

## Test plan

- Reset: hold RST 2 cycles after arbitrary writes. Required: all reads return 0 and INTR=0.
- One-shot: COUNT=3, CTRL=0x5 (EN, IE, P=0). Required:
  - INTR rises exactly 4 cycles after the CTRL edge.
  - CTRL reads 0x4 afterwards.
  - COUNT stays 0.
  - Writing STATUS=1 drops INTR on the next cycle.
- Auto-reload with prescale: RELOAD=2, COUNT=2, CTRL=0x0207. Required:
  - EXP sets every 9 cycles.
  - COUNT reads the sequence 2,1,0,2 with each value held 3 cycles.
  - INTR stays high until cleared.
- Collisions:
  - A COUNT write of 5 on the expiry tick. Required: no EXP, COUNT=5.
  - A STATUS clear on the expiry cycle. Required: EXP=1.
- Decode: writes to BASE+0x10 and to BASE with a different upper nibble. Required: no register changes and RD_DATA=0. A write to BASE+0x7 (bits [1:0]=3) updates COUNT.
- Reset mid-run: assert RST with COUNT=100 running and INTR high. Required: all registers 0 and INTR=0 after one edge; no expiry afterwards.
